// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register constants, state encoding and default payload layout
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  // Default-width payload; width-parametrised stages flatten {instr, pc, pc4, side} in this order
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [0:0]  side;
  } payload_t;
  function automatic int payload_w(input int xlen, input int side_w);
    return 3 * xlen + side_w;
  endfunction
endpackage

// File: rtl/if_id_skid_reg_if.sv
// if_id_skid_reg_if: fetch-to-decode valid/ready handshake and payload bundle
interface if_id_skid_reg_if #(
  parameter int XLEN   = 32,
  parameter int SIDE_W = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   instr_in;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   pc4_in;
  logic [SIDE_W-1:0] side_in;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   instr_out;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   pc4_out;
  logic [SIDE_W-1:0] side_out;
  logic              skid_full;
  modport slave (
    input  in_valid, instr_in, pc_in, pc4_in, side_in, out_ready,
    output in_ready, out_valid, instr_out, pc_out, pc4_out, side_out, skid_full
  );
  modport master (
    output in_valid, instr_in, pc_in, pc4_in, side_in, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, pc4_out, side_out, skid_full
  );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load, clear-to-empty-value and hold
module pipe_slot #(
  parameter int           W       = 97,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= (rst || clr) ? RST_VAL : load ? d : q;
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: fetch/decode pipeline register with valid/ready handshake and one-entry skid slot
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              SIDE_W    = 1,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input logic              clk,
  input logic              rst,
  input logic              start,
  input logic              flush,
  if_id_skid_reg_if.slave  bus
);
  localparam int           W        = payload_w(XLEN, SIDE_W);
  localparam logic [W-1:0] EMPTY_PL = {NOP_INSTR, {(2*XLEN+SIDE_W){1'b0}}};
  state_t       state, state_nxt;
  logic         accept, consume, advance;
  logic         hd_load, hd_clr, sk_load, sk_clr;
  logic [W-1:0] in_pl, hd_d, hd_q, sk_q;
  assign in_pl = {bus.instr_in, bus.pc_in, bus.pc4_in, bus.side_in};
  assign {bus.instr_out, bus.pc_out, bus.pc4_out, bus.side_out} = hd_q;
  always_ff @(posedge clk) state <= rst ? EMPTY : state_nxt;
  always_comb begin
    state_nxt = start ? state :
                flush ? EMPTY :
                (state == EMPTY) ? (accept ? ONE : EMPTY) :
                (state == ONE) ? ((accept && !consume) ? FULL : (!accept && consume) ? EMPTY : ONE) :
                (consume ? ONE : FULL);
  end
  // in_ready depends only on registered state and start, so fetch never sees out_ready combinationally
  always_comb begin
    bus.in_ready  = (state != FULL) && !start;
    bus.out_valid = (state != EMPTY);
    bus.skid_full = (state == FULL);
    accept        = bus.in_valid && bus.in_ready;
    consume       = bus.out_valid && bus.out_ready && !start;
    advance       = !start && !flush;
    hd_load       = advance && (((state == EMPTY) && accept) ||
                                ((state == ONE) && accept && consume) ||
                                ((state == FULL) && consume));
    hd_clr        = !start && (flush || (state_nxt == EMPTY));
    hd_d          = (state == FULL) ? sk_q : in_pl;
    sk_load       = advance && (state == ONE) && accept && !consume;
    sk_clr        = !start && (flush || ((state == FULL) && consume));
  end
  pipe_slot #(.W(W), .RST_VAL(EMPTY_PL)) u_head (
    .clk(clk), .rst(rst), .load(hd_load), .clr(hd_clr), .d(hd_d), .q(hd_q)
  );
  pipe_slot #(.W(W), .RST_VAL(EMPTY_PL)) u_skid (
    .clk(clk), .rst(rst), .load(sk_load), .clr(sk_clr), .d(in_pl), .q(sk_q)
  );
endmodule
